pixel_color_to_vec: RTL

- Inverse of the vector-to-pixel path: accepts a packed 24-bit RGB pixel and returns a 3-component IEEE-754 single-precision vector.
- Each 8-bit channel c is normalised to c/255 in the range [0.0, 1.0].
- Used where framebuffer or texture colours re-enter the float shading pipeline, for example blending and texture sampling.
- AXI-Stream style handshakes on both sides. Fully pipelined, one pixel per cycle, 2-cycle latency.

---
 rtl/float_pkg.sv | 29 ++
 rtl/u8_to_float.sv | 70 +++++++
 rtl/pixel_color_to_vec.sv | 99 +++++++++
 3 files changed

// File: rtl/float_pkg.sv
// float_pkg
// Shared constants and types for converting 8-bit colour channels into
// IEEE-754 single-precision floats.
//   FLOAT_ONE / FLOAT_ZERO : bit patterns for 1.0 and +0.0
//   EXP_BIAS               : single-precision exponent bias
//   RECIP255_MULT          : multiplier giving c/255 scaled by 2^24 (truncated)
//   PROD_WIDTH             : width of the scaled product
//   float_t                : unpacked sign/exponent/mantissa view of a float
package float_pkg;

  localparam int          FLOAT_WIDTH   = 32;
  localparam logic [31:0] FLOAT_ONE     = 32'h3F800000;
  localparam logic [31:0] FLOAT_ZERO    = 32'h00000000;
  localparam int          EXP_BIAS      = 127;
  localparam logic [23:0] RECIP255_MULT = 24'h010101;
  localparam int          PROD_WIDTH    = 24;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_t;

  // Flatten the field view into the 32-bit IEEE-754 bit pattern.
  function automatic logic [31:0] pack_float(input float_t f);
    return {f.sign, f.exp, f.mant};
  endfunction

endpackage

// File: rtl/u8_to_float.sv
// u8_to_float
// Combinational datapath for one colour channel, split in two halves so the
// parent can place a register stage between them.
//   Front half (feeds S1 registers):
//     chan      : 8-bit channel value c
//     prod      : c * 0x010101, i.e. c/255 * (1 - 2^-24) scaled by 2^24
//     lead_pos  : bit position of the leading one in prod
//     is_zero   : c == 0
//     is_full   : c == 255
//   Back half (driven from S1 registers, feeds S2 registers):
//     s2_prod, s2_lead_pos, s2_zero, s2_full : registered front-half values
//     result    : packed single-precision float
module u8_to_float
  import float_pkg::*;
(
  input  logic [7:0]  chan,
  output logic [23:0] prod,
  output logic [4:0]  lead_pos,
  output logic        is_zero,
  output logic        is_full,
  input  logic [23:0] s2_prod,
  input  logic [4:0]  s2_lead_pos,
  input  logic        s2_zero,
  input  logic        s2_full,
  output logic [31:0] result
);

  logic [4:0]  shamt;
  logic [22:0] mant_bits;
  float_t      fval;

  // The multiply by 0x010101 never overflows 24 bits (255 * 0x010101 is
  // 0xFFFFFF), and it reduces to replicating c three times, so synthesis
  // folds it to wiring.
  always_comb begin
    prod    = {16'd0, chan} * RECIP255_MULT;
    is_zero = (chan == 8'd0);
    is_full = (chan == 8'hFF);
  end

  // Leading-one detect: scanning upwards leaves the highest set bit last.
  // For c == 0 the position is meaningless and the zero flag takes over.
  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < PROD_WIDTH; i++) begin
      if (prod[i]) lead_pos = 5'(i);
    end
  end

  // Normalise: shift the leading one up to bit 23 and keep the 23 bits
  // below it. Every product bit fits in the mantissa, so truncation loses
  // nothing beyond the 2^-24 already baked into the multiplier. The
  // exponent is bias - (24 - p), i.e. 103 + p. Zero and 255 are forced
  // to their exact encodings.
  always_comb begin
    shamt       = 5'd23 - s2_lead_pos;
    mant_bits   = 23'(s2_prod << shamt);
    fval.sign   = 1'b0;
    fval.exp    = 8'(EXP_BIAS - PROD_WIDTH) + {3'b000, s2_lead_pos};
    fval.mant   = mant_bits;
    if (s2_zero) begin
      result = FLOAT_ZERO;
    end else if (s2_full) begin
      result = FLOAT_ONE;
    end else begin
      result = pack_float(fval);
    end
  end

endmodule

// File: rtl/pixel_color_to_vec.sv
// pixel_color_to_vec
// Converts a packed 24-bit RGB pixel into three single-precision floats,
// each channel normalised to c/255. Two register stages (S1, S2), one
// pixel per cycle, 2-cycle latency, AXI-Stream handshakes on both sides.
//   aclk, aresetn         : clock, asynchronous active-low reset
//   s_axis_a_tdata[23:0]  : pixel; byte i is channel i
//   s_axis_a_tvalid/ready : input handshake
//   m_axis_result_tdata   : [2:0][SIZE-1:0] float vector; element i <- channel i
//   m_axis_result_tvalid/ready : output handshake
module pixel_color_to_vec
  import float_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [23:0]          s_axis_a_tdata,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  output logic [2:0][SIZE-1:0] m_axis_result_tdata,
  output logic                 m_axis_result_tvalid,
  input  logic                 m_axis_result_tready
);

  if (SIZE != FLOAT_WIDTH) begin : g_size_check
    $error("pixel_color_to_vec: SIZE must be 32");
  end

  logic                 s1_valid;
  logic [2:0][23:0]     s1_prod;
  logic [2:0][4:0]      s1_lead;
  logic [2:0]           s1_zero;
  logic [2:0]           s1_full;

  logic [2:0][23:0]     c_prod;
  logic [2:0][4:0]      c_lead;
  logic [2:0]           c_zero;
  logic [2:0]           c_full;
  logic [2:0][SIZE-1:0] c_result;

  logic s2_advance;
  logic s1_advance;

  // S2 moves when it is empty or the consumer takes its beat; S1 moves when
  // it is empty or S2 moves. This lets a full pipeline accept and emit in
  // the same cycle without a bubble. Ready is held low during reset.
  always_comb begin
    s2_advance      = !m_axis_result_tvalid || m_axis_result_tready;
    s1_advance      = !s1_valid || s2_advance;
    s_axis_a_tready = aresetn && s1_advance;
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    u8_to_float u_conv (
      .chan        (s_axis_a_tdata[8*i +: 8]),
      .prod        (c_prod[i]),
      .lead_pos    (c_lead[i]),
      .is_zero     (c_zero[i]),
      .is_full     (c_full[i]),
      .s2_prod     (s1_prod[i]),
      .s2_lead_pos (s1_lead[i]),
      .s2_zero     (s1_zero[i]),
      .s2_full     (s1_full[i]),
      .result      (c_result[i])
    );
  end

  // Pipeline registers. Payloads only load when a valid beat moves in, so
  // a stalled S2 keeps its data stable. Reset clears everything at once,
  // dropping any in-flight beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid             <= 1'b0;
      s1_prod              <= '0;
      s1_lead              <= '0;
      s1_zero              <= '0;
      s1_full              <= '0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
    end else begin
      if (s2_advance) begin
        m_axis_result_tvalid <= s1_valid;
        if (s1_valid) begin
          m_axis_result_tdata <= c_result;
        end
      end
      if (s1_advance) begin
        s1_valid <= s_axis_a_tvalid;
        if (s_axis_a_tvalid) begin
          s1_prod <= c_prod;
          s1_lead <= c_lead;
          s1_zero <= c_zero;
          s1_full <= c_full;
        end
      end
    end
  end

endmodule
